instruction_register: RTL and testbench
=======================================

INSTRUCTION_REGISTER -- requirements
Module: instruction_register

Interface
REQ-001 Parameter: RESET_VALUE, default 32'h0000_0000, value loaded into the instruction register on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ir_write  input  1  load enable; when high, instruction_in is captured at the next clk rising edge.
REQ-005 instruction_in  input  32  instruction word fetched from memory.
REQ-006 instruction_out  output  32  currently held instruction word.
REQ-007 opcode  output  7  instruction_out[6:0].
REQ-008 rd  output  5  instruction_out[11:7].
REQ-009 funct3  output  3  instruction_out[14:12].
REQ-010 rs1  output  5  instruction_out[19:15].
REQ-011 rs2  output  5  instruction_out[24:20].
REQ-012 funct7  output  7  instruction_out[31:25].
REQ-013 imm  output  32  sign-extended immediate decoded from the held instruction.
REQ-014 inst_type  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, unknown=7.

Function
REQ-015 The block SHALL hold one 32-bit register; instruction_out SHALL be driven directly from it.
REQ-016 At a rising edge with reset=1, the register SHALL load RESET_VALUE, whatever the state of ir_write.
REQ-017 At a rising edge with reset=0 and ir_write=1, the register SHALL load instruction_in, so the new word is visible one cycle later.
REQ-018 At a rising edge with reset=0 and ir_write=0, the register SHALL keep its value; changes on instruction_in SHALL have no effect.
REQ-019 opcode, rd, funct3, rs1, rs2 and funct7 SHALL be combinational slices of the register, extracted for every format and never gated.
REQ-020 inst_type SHALL be decoded combinationally from opcode:
- 0110011 -> R
- 0010011, 0000011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- any other opcode -> 7
REQ-021 imm SHALL be formed per format (ins = instruction_out):
- I: sext(ins[31:20])
- S: sext({ins[31:25], ins[11:7]})
- B: sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})
- U: {ins[31:12], 12'b0}
- J: sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})
- R and unknown: 0
REQ-022 All decoded outputs SHALL change only when the register changes; there SHALL be no other internal state.
REQ-023 If reset is asserted mid-stream, the reset value SHALL be visible on the cycle after the reset edge, and normal loading SHALL resume on the first edge with reset=0.

Reset
REQ-024 After reset (RESET_VALUE=0), outputs SHALL be:
- instruction_out = 0, opcode = 0, rd = 0, rs1 = 0, rs2 = 0, funct3 = 0, funct7 = 0
- imm = 0
- inst_type = 7, because opcode 0000000 is unknown.
REQ-025 No reset SHALL be required for correct decoding; the outputs SHALL be a pure function of the register.

Verification
REQ-026 Load 0x003100B3 with ir_write=1 for one cycle, then ir_write=0 -> instruction_out=0x003100B3, opcode=0110011, rd=1, rs1=2, rs2=3, funct3=000, funct7=0000000, inst_type=0, imm=0.
REQ-027 Load 0x02A28213 -> opcode=0010011, rd=4, rs1=5, funct3=000, inst_type=1, imm=42.
REQ-028 With ir_write=0, drive instruction_in=0xFFFFFFFF for one or more cycles -> instruction_out stays 0x02A28213.
REQ-029 Load 0x0063A423 -> opcode=0100011, rs1=7, rs2=6, funct3=010, inst_type=2, imm=8.
REQ-030 Assert reset=1 for one cycle, also with ir_write=1 and a nonzero instruction_in -> instruction_out=0 and all fields 0 on the following cycle.
REQ-031 Load 0xFE000EE3 (B-type) -> inst_type=3, imm=0xFFFFFFFC (negative sign extension).

Source files
------------

// File: rtl/instruction_register.sv
// Instruction register with combinational RV32 field extraction,
// format classification and sign-extended immediate generation.
module instruction_register #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_write,
    input  logic [31:0] instruction_in,
    output logic [31:0] instruction_out,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [2:0]  inst_type
);

    localparam logic [2:0] TypeR       = 3'd0;
    localparam logic [2:0] TypeI       = 3'd1;
    localparam logic [2:0] TypeS       = 3'd2;
    localparam logic [2:0] TypeB       = 3'd3;
    localparam logic [2:0] TypeU       = 3'd4;
    localparam logic [2:0] TypeJ       = 3'd5;
    localparam logic [2:0] TypeUnknown = 3'd7;

    logic [31:0] instr_q;
    logic [31:0] instr_d;

    // Next-state: load on ir_write, otherwise hold.
    always_comb begin
        instr_d = instr_q;
        if (ir_write) begin
            instr_d = instruction_in;
        end
    end

    // Single instruction register; reset overrides any pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= RESET_VALUE;
        end else begin
            instr_q <= instr_d;
        end
    end

    assign instruction_out = instr_q;

    // Raw fields are extracted for every format, never gated by type.
    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    // Classify the held instruction by opcode.
    always_comb begin
        inst_type = TypeUnknown;
        unique case (instr_q[6:0])
            7'b0110011: inst_type = TypeR;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: inst_type = TypeI;
            7'b0100011: inst_type = TypeS;
            7'b1100011: inst_type = TypeB;
            7'b0110111,
            7'b0010111: inst_type = TypeU;
            7'b1101111: inst_type = TypeJ;
            default:    inst_type = TypeUnknown;
        endcase
    end

    // Assemble the immediate for the decoded format; R and unknown give zero.
    always_comb begin
        imm = 32'h0000_0000;
        unique case (inst_type)
            TypeI:   imm = {{20{instr_q[31]}}, instr_q[31:20]};
            TypeS:   imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            TypeB:   imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                            instr_q[30:25], instr_q[11:8], 1'b0};
            TypeU:   imm = {instr_q[31:12], 12'h000};
            TypeJ:   imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                            instr_q[20], instr_q[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_instruction_register.sv
// Directed self-checking bench for instruction_register.
module tb_instruction_register;

    logic        clk;
    logic        reset;
    logic        ir_write;
    logic [31:0] instruction_in;
    logic [31:0] instruction_out;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  inst_type;

    int n_assert = 0;
    int n_fail   = 0;

    instruction_register #(
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ir_write       (ir_write),
        .instruction_in (instruction_in),
        .instruction_out(instruction_out),
        .opcode         (opcode),
        .rd             (rd),
        .funct3         (funct3),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct7         (funct7),
        .imm            (imm),
        .inst_type      (inst_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the following rising edge.
    task automatic step(input logic rst, input logic wr, input logic [31:0] din);
        reset          = rst;
        ir_write       = wr;
        instruction_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input string tag, input logic [6:0] e_op, input logic [4:0] e_rd,
                                input logic [2:0] e_f3, input logic [4:0] e_rs1,
                                input logic [4:0] e_rs2, input logic [6:0] e_f7);
        check({tag, ".opcode"}, {25'd0, opcode}, {25'd0, e_op});
        check({tag, ".rd"},     {27'd0, rd},     {27'd0, e_rd});
        check({tag, ".funct3"}, {29'd0, funct3}, {29'd0, e_f3});
        check({tag, ".rs1"},    {27'd0, rs1},    {27'd0, e_rs1});
        check({tag, ".rs2"},    {27'd0, rs2},    {27'd0, e_rs2});
        check({tag, ".funct7"}, {25'd0, funct7}, {25'd0, e_f7});
    endtask

    initial begin
        reset          = 1'b1;
        ir_write       = 1'b0;
        instruction_in = 32'h0;
        #2;

        // Reset state
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("rst.instr", instruction_out, 32'h0);
        check_fields("rst", 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00);
        check("rst.imm", imm, 32'h0);
        check("rst.type", {29'd0, inst_type}, 32'd7);

        // R-type add x1,x2,x3
        step(1'b0, 1'b1, 32'h003100B3);
        step(1'b0, 1'b0, 32'h0);
        check("r.instr", instruction_out, 32'h003100B3);
        check_fields("r", 7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0);
        check("r.type", {29'd0, inst_type}, 32'd0);
        check("r.imm", imm, 32'h0);

        // I-type addi x4,x5,42
        step(1'b0, 1'b1, 32'h02A28213);
        check("i.instr", instruction_out, 32'h02A28213);
        check({25'd0, opcode} == {25'd0, 7'b0010011} ? "i.op" : "i.op", {25'd0, opcode},
              {25'd0, 7'b0010011});
        check("i.rd", {27'd0, rd}, 32'd4);
        check("i.rs1", {27'd0, rs1}, 32'd5);
        check("i.funct3", {29'd0, funct3}, 32'd0);
        check("i.type", {29'd0, inst_type}, 32'd1);
        check("i.imm", imm, 32'd42);

        // Hold: ir_write low, input changes ignored
        step(1'b0, 1'b0, 32'hFFFFFFFF);
        check("hold1.instr", instruction_out, 32'h02A28213);
        step(1'b0, 1'b0, 32'hFFFFFFFF);
        check("hold2.instr", instruction_out, 32'h02A28213);
        check("hold.imm", imm, 32'd42);

        // S-type sw x6,8(x7)
        step(1'b0, 1'b1, 32'h0063A423);
        check("s.instr", instruction_out, 32'h0063A423);
        check_fields("s", 7'b0100011, 5'd8, 3'b010, 5'd7, 5'd6, 7'd0);
        check("s.type", {29'd0, inst_type}, 32'd2);
        check("s.imm", imm, 32'd8);

        // Reset wins over a simultaneous load
        step(1'b1, 1'b1, 32'hDEADBEEF);
        check("rstw.instr", instruction_out, 32'h0);
        check_fields("rstw", 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00);
        check("rstw.imm", imm, 32'h0);
        check("rstw.type", {29'd0, inst_type}, 32'd7);

        // B-type, negative offset; first edge after reset loads normally
        step(1'b0, 1'b1, 32'hFE000EE3);
        check("b.instr", instruction_out, 32'hFE000EE3);
        check("b.type", {29'd0, inst_type}, 32'd3);
        check("b.imm", imm, 32'hFFFFFFFC);

        // I-type negative immediate: addi x1,x0,-1
        step(1'b0, 1'b1, 32'hFFF00093);
        check("ineg.type", {29'd0, inst_type}, 32'd1);
        check("ineg.imm", imm, 32'hFFFFFFFF);

        // U-type lui
        step(1'b0, 1'b1, 32'h12345037);
        check("u.type", {29'd0, inst_type}, 32'd4);
        check("u.imm", imm, 32'h12345000);
        check("u.rd", {27'd0, rd}, 32'd0);

        // U-type auipc x2 with top bit set (no extension beyond the shift)
        step(1'b0, 1'b1, 32'h80000117);
        check("ua.type", {29'd0, inst_type}, 32'd4);
        check("ua.imm", imm, 32'h80000000);
        check("ua.rd", {27'd0, rd}, 32'd2);

        // J-type jal x1,-4
        step(1'b0, 1'b1, 32'hFFDFF0EF);
        check("j.type", {29'd0, inst_type}, 32'd5);
        check("j.imm", imm, 32'hFFFFFFFC);
        check("j.rd", {27'd0, rd}, 32'd1);

        // J-type positive offset jal x0,+2048 (exercises ins[20] -> imm[11])
        step(1'b0, 1'b1, 32'h0010006F);
        check("jp.imm", imm, 32'h00000800);

        // Other I-type opcodes: lw, jalr, csr/system
        step(1'b0, 1'b1, 32'h80002083);
        check("lw.type", {29'd0, inst_type}, 32'd1);
        check("lw.imm", imm, 32'hFFFFF800);
        step(1'b0, 1'b1, 32'h00008067);
        check("jalr.type", {29'd0, inst_type}, 32'd1);
        step(1'b0, 1'b1, 32'h00000073);
        check("sys.type", {29'd0, inst_type}, 32'd1);

        // Unknown opcode with fields still sliced, immediate zero
        step(1'b0, 1'b1, 32'hFFFFFFFF);
        check("unk.type", {29'd0, inst_type}, 32'd7);
        check("unk.imm", imm, 32'h0);
        check_fields("unk", 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F);

        // R-type with nonzero funct7 (sub) keeps imm at zero
        step(1'b0, 1'b1, 32'h40208033);
        check("sub.type", {29'd0, inst_type}, 32'd0);
        check("sub.funct7", {25'd0, funct7}, 32'h20);
        check("sub.imm", imm, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
